mmio_frame_sequencer: RTL and testbench

//  Bus initiator for the coprocessor MMIO address space; mmio is the responder.
//  On each frame tick it walks a programmable command table. For each enabled entry it

---
 rtl/mmio_pkg.sv | 45 ++++
 rtl/mmio_seq_table.sv | 34 +++
 rtl/mmio_frame_sequencer.sv | 144 ++++++++++++++
 tb/tb_mmio_frame_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO frame sequencer: FSM encoding, command entry
// layout within cfg_data, and well-known coprocessor MMIO addresses.
package mmio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SCAN,
        ST_RD,
        ST_WR,
        ST_FIN
    } seq_state_t;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int SRC_LSB  = 0;
    localparam int DST_LSB  = 13;
    localparam int EN_BIT   = 26;
    localparam int LAST_BIT = 27;
    localparam int ENTRY_W  = 28;

    localparam logic [ADDR_W-1:0] COPROC_SPACE = 13'h1000;
    localparam logic [ADDR_W-1:0] PHYS_P1      = 13'h1000;
    localparam logic [ADDR_W-1:0] PHYS_P2      = 13'h1080;
    localparam logic [ADDR_W-1:0] VGA_P1       = 13'h1400;
    localparam logic [ADDR_W-1:0] VGA_P2       = 13'h1480;
    localparam logic [ADDR_W-1:0] COLL_P1      = 13'h1600;

    typedef struct packed {
        logic              last;
        logic              en;
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] src;
    } seq_entry_t;

    function automatic seq_entry_t unpack_entry(input logic [ENTRY_W-1:0] d);
        seq_entry_t e;
        e.src  = d[SRC_LSB +: ADDR_W];
        e.dst  = d[DST_LSB +: ADDR_W];
        e.en   = d[EN_BIT];
        e.last = d[LAST_BIT];
        return e;
    endfunction

endpackage

// File: rtl/mmio_seq_table.sv
// Command table register file: one synchronous write port, one async read port.
// Latency: write visible on the edge after wr_en; read is combinational.
// Backpressure: none; the caller gates wr_en while a pass is running.
module mmio_seq_table
    import mmio_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int IW          = $clog2(NUM_ENTRIES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  seq_entry_t    wr_entry,
    input  logic [IW-1:0] rd_idx,
    output seq_entry_t    rd_entry
);

    seq_entry_t mem [NUM_ENTRIES];

    // Loop-compare write so indices beyond NUM_ENTRIES fall away silently.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (IW'(i) == wr_idx) mem[i] <= wr_entry;
            end
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/mmio_frame_sequencer.sv
// Per-frame MMIO copy engine: walks the command table, reading src and writing dst.
// Latency: enabled entry 3+READ_LATENCY cycles, disabled entry 1 cycle, plus ARB and FIN.
// Backpressure: losing bus_gnt freezes state/idx, masks bus_wren and restarts the read wait.
module mmio_frame_sequencer
    import mmio_pkg::*;
#(
    parameter int NUM_ENTRIES  = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              cfg_wren,
    input  logic [4:0]        cfg_index,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              ovr_clr,
    input  logic              bus_gnt,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wren,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int IW = $clog2(NUM_ENTRIES);

    seq_state_t        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q;
    seq_entry_t        cur;
    logic              last_slot;

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{cfg_data[DATA_W-1:ENTRY_W], cfg_index};

    mmio_seq_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IW          (IW)
    ) u_table (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (cfg_wren && (state_q == ST_IDLE)),
        .wr_idx   (cfg_index[IW-1:0]),
        .wr_entry (unpack_entry(cfg_data[ENTRY_W-1:0])),
        .rd_idx   (idx_q),
        .rd_entry (cur)
    );

    assign last_slot = cur.last || (idx_q == IW'(NUM_ENTRIES - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_ARB;
                    idx_d   = '0;
                end
            end
            ST_ARB: begin
                if (bus_gnt) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (bus_gnt) begin
                    if (cur.en) begin
                        state_d = ST_RD;
                        cnt_d   = '0;
                    end else if (last_slot) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_RD: begin
                if (!bus_gnt) begin
                    cnt_d = '0;
                end else if (cnt_q == 2'(READ_LATENCY)) begin
                    data_d  = bus_rdata;
                    state_d = ST_WR;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_WR: begin
                if (bus_gnt) begin
                    if (last_slot) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state; idx never changes on entry to RD/WR,
    // so the current table entry already describes the next cycle's transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            bus_req     <= 1'b0;
            bus_address <= '0;
            bus_wdata   <= '0;
            wren_q      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            bus_req     <= (state_d == ST_ARB) || (state_d == ST_SCAN) ||
                           (state_d == ST_RD)  || (state_d == ST_WR);
            bus_address <= (state_d == ST_RD) ? cur.src :
                           (state_d == ST_WR) ? cur.dst : '0;
            bus_wdata   <= (state_d == ST_WR) ? data_d : '0;
            wren_q      <= (state_d == ST_WR);
            if (ovr_clr)
                overrun <= 1'b0;
            else if (frame_tick && (state_q != ST_IDLE))
                overrun <= 1'b1;
        end
    end

    // Grant can vanish within a write cycle; the replay happens when it returns.
    assign bus_wren = wren_q && bus_gnt;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);

endmodule

// File: tb/tb_mmio_frame_sequencer.sv
// Directed bench for mmio_frame_sequencer with a 1-cycle-latency MMIO responder model.
module tb_mmio_frame_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        cfg_wren = 1'b0;
    logic [4:0]  cfg_index = '0;
    logic [31:0] cfg_data = '0;
    logic        ovr_clr = 1'b0;
    logic        bus_gnt = 1'b1;
    logic [31:0] bus_rdata = '0;
    logic        bus_req;
    logic [12:0] bus_address;
    logic [31:0] bus_wdata;
    logic        bus_wren;
    logic        busy;
    logic        done;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int cyc;
    int base_done;

    logic [31:0] mem [0:8191];
    logic [12:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    mmio_frame_sequencer #(.NUM_ENTRIES(8), .READ_LATENCY(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .cfg_wren    (cfg_wren),
        .cfg_index   (cfg_index),
        .cfg_data    (cfg_data),
        .ovr_clr     (ovr_clr),
        .bus_gnt     (bus_gnt),
        .bus_rdata   (bus_rdata),
        .bus_req     (bus_req),
        .bus_address (bus_address),
        .bus_wdata   (bus_wdata),
        .bus_wren    (bus_wren),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        bus_rdata <= mem[bus_address];
        if (bus_wren) begin
            wr_addr_q.push_back(bus_address);
            wr_data_q.push_back(bus_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic [12:0] src, input logic [12:0] dst,
                                        input logic en, input logic last);
        return {4'h0, last, en, dst, src};
    endfunction

    task automatic cfg_write(input int idx, input logic [31:0] d);
        cfg_wren  = 1'b1;
        cfg_index = 5'(idx);
        cfg_data  = d;
        @(negedge clock);
        cfg_wren  = 1'b0;
    endtask

    // Returns in the middle of the ARB cycle.
    task automatic start_pass();
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                c = k;
                break;
            end
        end
        @(negedge clock);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[13'h1000] = 32'h016000FA;
        mem[13'h1080] = 32'h01A900FA;
        mem[13'h1600] = 32'hCAFE0001;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_req", {31'd0, bus_req}, 32'd0);
        check("rst_addr", {19'd0, bus_address}, 32'd0);
        check("rst_wren_busy_done_ovr", {28'd0, bus_wren, busy, done, overrun}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 1: two enabled entries
        cfg_write(0, ent(13'h1000, 13'h1400, 1'b1, 1'b0));
        cfg_write(1, ent(13'h1080, 13'h1480, 1'b1, 1'b1));
        clear_log();
        start_pass();
        check("t1_arb_req_busy", {30'd0, bus_req, busy}, 32'd3);
        wait_done(cyc);
        check("t1_done_cycle", cyc, 9);
        check("t1_nwrites", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("t1_w0_addr", {19'd0, wr_addr_q[0]}, 32'h1400);
            check("t1_w0_data", wr_data_q[0], 32'h016000FA);
            check("t1_w1_addr", {19'd0, wr_addr_q[1]}, 32'h1480);
            check("t1_w1_data", wr_data_q[1], 32'h01A900FA);
        end
        check("t1_idle_after", {29'd0, busy, done, bus_req}, 32'd0);

        // 2: skip two disabled entries
        cfg_write(0, ent(13'h1000, 13'h1400, 1'b0, 1'b0));
        cfg_write(1, ent(13'h1080, 13'h1480, 1'b0, 1'b0));
        cfg_write(2, ent(13'h1600, 13'h1480, 1'b1, 1'b1));
        clear_log();
        start_pass();
        wait_done(cyc);
        check("t2_done_cycle", cyc, 7);
        check("t2_nwrites", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("t2_addr", {19'd0, wr_addr_q[0]}, 32'h1480);
            check("t2_data", wr_data_q[0], 32'hCAFE0001);
        end

        // 3: grant lost during WR of entry 0
        cfg_write(0, ent(13'h1000, 13'h1400, 1'b1, 1'b1));
        clear_log();
        start_pass();
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (bus_wren === 1'b1) begin
                cyc = k;
                break;
            end
        end
        check("t3_wr_cycle", cyc, 4);
        bus_gnt = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("t3_wren_masked", {31'd0, bus_wren}, 32'd0);
            check("t3_addr_held", {19'd0, bus_address}, 32'h1400);
        end
        check("t3_no_partial", wr_addr_q.size(), 0);
        bus_gnt = 1'b1;
        wait_done(cyc);
        check("t3_done_after_replay", cyc, 1);
        check("t3_nwrites", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("t3_addr", {19'd0, wr_addr_q[0]}, 32'h1400);
            check("t3_data", wr_data_q[0], 32'h016000FA);
        end

        // 4: overrun
        clear_log();
        base_done = done_cnt;
        start_pass();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        check("t4_overrun_set", {31'd0, overrun}, 32'd1);
        wait_done(cyc);
        check("t4_done_cycle", cyc, 3);
        check("t4_one_done", done_cnt - base_done, 1);
        check("t4_nwrites", wr_addr_q.size(), 1);
        check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
        start_pass();
        frame_tick = 1'b1;
        ovr_clr    = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        ovr_clr    = 1'b0;
        check("t4_clr_wins", {31'd0, overrun}, 32'd0);
        wait_done(cyc);

        // 5: table writes ignored while busy
        clear_log();
        start_pass();
        cfg_write(0, ent(13'h1080, 13'h1600, 1'b1, 1'b1));
        wait_done(cyc);
        start_pass();
        wait_done(cyc);
        check("t5_nwrites", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("t5_old_addr", {19'd0, wr_addr_q[1]}, 32'h1400);
            check("t5_old_data", wr_data_q[1], 32'h016000FA);
        end
        clear_log();
        cfg_wren   = 1'b1;
        cfg_index  = 5'd0;
        cfg_data   = ent(13'h1080, 13'h1600, 1'b1, 1'b1);
        frame_tick = 1'b1;
        @(negedge clock);
        cfg_wren   = 1'b0;
        frame_tick = 1'b0;
        wait_done(cyc);
        check("t5_new_nwrites", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("t5_new_addr", {19'd0, wr_addr_q[0]}, 32'h1600);
            check("t5_new_data", wr_data_q[0], 32'h01A900FA);
        end

        // 6: reset during RD of entry 1
        cfg_write(0, ent(13'h1000, 13'h1400, 1'b1, 1'b0));
        cfg_write(1, ent(13'h1080, 13'h1480, 1'b1, 1'b1));
        start_pass();
        repeat (6) @(negedge clock);
        check("t6_in_rd1", {19'd0, bus_address}, 32'h1080);
        reset = 1'b0;
        #1;
        check("t6_async_req", {31'd0, bus_req}, 32'd0);
        check("t6_async_addr", {19'd0, bus_address}, 32'd0);
        check("t6_async_rest", {28'd0, bus_wren, busy, done, overrun}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        clear_log();
        start_pass();
        wait_done(cyc);
        check("t6_done_cycle", cyc, 9);
        check("t6_no_writes", wr_addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
